fp_normalizer_seq: RTL and testbench
====================================

Name: fp_normalizer_seq

Overview:
- Post-add normalization stage of the 32-bit floating-point adder.
- Consumes the raw 25-bit mantissa sum (carry + hidden + fraction) and the provisional exponent from the mantissa adder stage.
- Normalizes with one right shift or iterative single-bit left shifts, one per cycle.
- Emits a normalized sign/exponent/fraction with zero, overflow and underflow flags over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; input mantissa width is FRAC_W+2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result valid.
- in_ready  output  1  block can accept; equals (state==IDLE) and not rst.
- in_sign  input  1  result sign.
- in_exp  input  EXP_W  provisional biased exponent.
- in_mant  input  FRAC_W+2  bit24 carry-out, bit23 hidden bit, bits22:0 fraction.
- out_valid  output  1  normalized result valid.
- out_ready  input  1  downstream accepts.
- out_sign  output  1  sign, passed through; forced 0 on zero result.
- out_exp  output  EXP_W  normalized biased exponent.
- out_frac  output  FRAC_W  normalized fraction, hidden bit dropped.
- out_zero  output  1  result is exact zero or flushed underflow.
- out_ovf  output  1  exponent overflow; result is infinity.
- out_unf  output  1  underflow flushed to zero.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset forces: state IDLE, all output registers 0, out_valid 0, in_ready 0 while rst is high.
- Reset mid-operation discards the operation. in_ready returns to 1 in the first cycle after rst falls.
- States:
  - IDLE: in_ready=1. On in_valid at a clock edge, latch sign/exp/mant and go to CHECK.
  - CHECK, one cycle:
    - mant==0: zero=1, exp=0, frac=0, sign=0, go to DONE.
    - in_exp==all-ones: ovf=1, exp=all-ones, frac=0, go to DONE.
    - mant[24]=1: shift right 1 (truncate, no rounding), exp+1. If the new exp is all-ones, set ovf=1 and frac=0. Go to DONE.
    - mant[23]=1: go to DONE unchanged.
    - Otherwise go to SHIFT.
  - SHIFT: each cycle test exp before shifting.
    - exp<=1: unf=1, zero=1, exp=0, frac=0, go to DONE.
    - Otherwise: mant<<1, exp-1. If pre-shift mant[22]=1, go to DONE; else stay in SHIFT.
    - A shift counter limits residency to FRAC_W cycles as a guard.
  - DONE: out_valid=1. All outputs held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops next cycle.
- Latency:
  - out_valid asserts 2 cycles after the accepting edge for no-shift, right-shift, zero and overflow cases.
  - Add k cycles for k left shifts; maximum 2+FRAC_W.
- Throughput: one result per operation. No overlap; in_ready is low from CHECK through the DONE handshake.
- Exponent arithmetic is EXP_W bits unsigned; the overflow/underflow checks above prevent any wrap.
- out_frac is mant[FRAC_W-1:0] after normalization.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, EXP_MAX (all-ones), BIAS=127.
  - State enum IDLE/CHECK/SHIFT/DONE.
- One sub-module, fp_exp_incdec: EXP_W-bit +1/-1 unit built as a ripple chain of the existing half-adder cell.
  - Inputs exp and dir; outputs result and a carry/borrow flag.
- All other logic is inline.

Test Plan:
- in_mant=25'h0800000, exp=8'h80, sign=1 -> out_exp=8'h80, frac=0, sign=1, flags 0; out_valid 2 cycles after accept.
- in_mant=25'h1800000, exp=8'h7F -> right shift; out_exp=8'h80, frac=23'h400000; latency 2.
- in_mant=25'h0000001, exp=8'h7F -> 23 left shifts; out_exp=8'h68, frac=0; latency 25.
- in_mant=0, exp=8'h90, sign=1 -> out_zero=1, exp=0, frac=0, sign=0.
- in_mant=25'h1000000, exp=8'hFE -> out_ovf=1, exp=8'hFF, frac=0.
- in_mant=25'h0200000, exp=8'h02 -> first shift gives exp 1, next cycle out_unf=1 and out_zero=1.
  - Separately: hold out_ready=0 for 3 cycles and check outputs are stable.
  - Separately: assert rst during SHIFT and check out_valid=0, then in_ready=1 the cycle after rst falls.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and FSM state encoding for the FP adder datapath stages.
package fp_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam int BIAS = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/fp_exp_incdec.sv
// Exponent +1/-1 unit: a half-adder ripple incrementer, with a decrement done as ~(~x + 1).
module fp_exp_incdec #(
  parameter int W = 8
) (
  input  logic [W-1:0] exp,
  input  logic         dir,     // 0: +1, 1: -1
  output logic [W-1:0] result,
  output logic         carry    // wrap on +1, borrow on -1
);
  logic [W-1:0] x, s;
  logic [W:0]   c;

  assign x    = exp ^ {W{dir}};
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_ha
    fp_half_adder u_ha (.a(x[i]), .b(c[i]), .s(s[i]), .c(c[i+1]));
  end

  assign result = s ^ {W{dir}};
  assign carry  = c[W];
endmodule

// File: rtl/fp_half_adder.sv
// Single-bit half-adder cell.
module fp_half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/fp_normalizer_seq.sv
// Post-add normalizer: one right shift or serial single-bit left shifts, then a
// held result on a valid/ready handshake.
module fp_normalizer_seq #(
  parameter int EXP_W  = fp_pkg::EXP_W,
  parameter int FRAC_W = fp_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W+1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_zero,
  output logic              out_ovf,
  output logic              out_unf
);
  import fp_pkg::*;

  localparam int MW = FRAC_W + 2;
  localparam int CW = $clog2(FRAC_W + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
    logic              zero;
    logic              ovf;
    logic              unf;
  } rsp_t;

  state_t            state;
  logic              sign_r;
  logic [EXP_W-1:0]  exp_r;
  logic [MW-1:0]     mant_r;
  logic [CW-1:0]     cnt;
  rsp_t              rsp_q;
  logic              vld_q;
  logic [EXP_W-1:0]  exp_nx;
  logic              exp_cy;

  // Increment in CHECK (right shift), decrement in SHIFT (left shift).
  fp_exp_incdec #(.W(EXP_W)) u_incdec (
    .exp    (exp_r),
    .dir    (state == SHIFT),
    .result (exp_nx),
    .carry  (exp_cy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sign_r <= 1'b0;
      exp_r  <= '0;
      mant_r <= '0;
      cnt    <= '0;
      rsp_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r <= in_sign;
            exp_r  <= in_exp;
            mant_r <= in_mant;
            cnt    <= '0;
            state  <= CHECK;
          end
        end
        CHECK: begin
          state <= DONE;
          if (mant_r == '0)
            rsp_q <= '{sign: 1'b0, exp: '0, frac: '0, zero: 1'b1, ovf: 1'b0, unf: 1'b0};
          else if (exp_r == EXP_ONES)
            rsp_q <= '{sign: sign_r, exp: EXP_ONES, frac: '0, zero: 1'b0, ovf: 1'b1, unf: 1'b0};
          else if (mant_r[MW-1]) begin
            if (exp_nx == EXP_ONES || exp_cy)
              rsp_q <= '{sign: sign_r, exp: EXP_ONES, frac: '0, zero: 1'b0, ovf: 1'b1, unf: 1'b0};
            else
              rsp_q <= '{sign: sign_r, exp: exp_nx, frac: mant_r[FRAC_W:1],
                         zero: 1'b0, ovf: 1'b0, unf: 1'b0};
          end else if (mant_r[FRAC_W])
            rsp_q <= '{sign: sign_r, exp: exp_r, frac: mant_r[FRAC_W-1:0],
                       zero: 1'b0, ovf: 1'b0, unf: 1'b0};
          else
            state <= SHIFT;
        end
        SHIFT: begin
          if (exp_r <= EXP_W'(1)) begin
            rsp_q <= '{sign: 1'b0, exp: '0, frac: '0, zero: 1'b1, ovf: 1'b0, unf: 1'b1};
            state <= DONE;
          end else begin
            mant_r <= mant_r << 1;
            exp_r  <= exp_nx;
            cnt    <= cnt + 1'b1;
            // Leading one lands on the hidden bit after this shift; the count is a backstop.
            if (mant_r[FRAC_W-1] || cnt == CW'(FRAC_W - 1)) begin
              rsp_q <= '{sign: sign_r, exp: exp_nx, frac: {mant_r[FRAC_W-2:0], 1'b0},
                         zero: 1'b0, ovf: 1'b0, unf: 1'b0};
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (vld_q && out_ready) begin
            vld_q <= 1'b0;
            state <= IDLE;
          end else begin
            vld_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = vld_q;
  assign out_sign  = rsp_q.sign;
  assign out_exp   = rsp_q.exp;
  assign out_frac  = rsp_q.frac;
  assign out_zero  = rsp_q.zero;
  assign out_ovf   = rsp_q.ovf;
  assign out_unf   = rsp_q.unf;
endmodule

// File: tb/tb_fp_normalizer_seq.sv
// Bench for fp_normalizer_seq: directed vector table, random ops against a reference model, hold and reset sequences.
module tb_fp_normalizer_seq;
  logic        clk, rst;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp;
  logic [24:0] in_mant;
  logic        out_valid, out_ready, out_sign;
  logic [7:0]  out_exp;
  logic [22:0] out_frac;
  logic        out_zero, out_ovf, out_unf;

  int errors = 0;
  int checks = 0;

  fp_normalizer_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        s;
    bit [7:0]  e;
    bit [22:0] f;
    bit        z, o, u;
    int        lat;
  } res_t;

  typedef struct {
    bit        s;
    bit [7:0]  e;
    bit [24:0] m;
    res_t      x;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: locate the leading one, count shifts, and decide overflow/underflow arithmetically.
  function automatic res_t model(input bit s, input bit [7:0] e, input bit [24:0] m);
    res_t r;
    int p, k, ei;
    bit [24:0] t;
    r = '{s: 0, e: 0, f: 0, z: 0, o: 0, u: 0, lat: 2};
    ei = int'(e);
    if (m == 0) r.z = 1;
    else if (ei == 255) begin r.s = s; r.e = 8'hFF; r.o = 1; end
    else if (m[24]) begin
      r.s = s;
      if (ei + 1 == 255) begin r.e = 8'hFF; r.o = 1; end
      else begin r.e = 8'(ei + 1); t = m >> 1; r.f = t[22:0]; end
    end else if (m[23]) begin r.s = s; r.e = e; r.f = m[22:0]; end
    else begin
      p = 0;
      for (int i = 0; i < 23; i++) if (m[i]) p = i;
      k = 23 - p;
      if (ei >= k + 1) begin
        r.s = s; r.e = 8'(ei - k); t = m << k; r.f = t[22:0]; r.lat = 2 + k;
      end else begin
        r.z = 1; r.u = 1; r.lat = 3 + ((ei > 1) ? ei - 1 : 0);
      end
    end
    return r;
  endfunction

  task automatic check_out(input string tag, input res_t x);
    check({tag, ".sign"}, 32'(out_sign), 32'(x.s));
    check({tag, ".exp"},  32'(out_exp),  32'(x.e));
    check({tag, ".frac"}, 32'(out_frac), 32'(x.f));
    check({tag, ".flags"}, 32'({out_zero, out_ovf, out_unf}), 32'({x.z, x.o, x.u}));
  endtask

  task automatic run_op(input string tag, input bit s, input bit [7:0] e, input bit [24:0] m,
                        input res_t x, input int hold);
    int  lat;
    bit  got;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      got = out_valid;
    end
    check({tag, ".latency"}, 32'(lat), 32'(x.lat));
    if (got) begin
      check_out(tag, x);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check($sformatf("%s.hold%0d.valid", tag, h), 32'(out_valid), 32'd1);
        check($sformatf("%s.hold%0d.in_ready", tag, h), 32'(in_ready), 32'd0);
        check_out($sformatf("%s.hold%0d", tag, h), x);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  vec_t vecs[8];
  res_t xr;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b1;

    vecs[0] = '{s: 1, e: 8'h80, m: 25'h0800000, x: '{s: 1, e: 8'h80, f: 23'h0,      z: 0, o: 0, u: 0, lat: 2}};
    vecs[1] = '{s: 0, e: 8'h7F, m: 25'h1800000, x: '{s: 0, e: 8'h80, f: 23'h400000, z: 0, o: 0, u: 0, lat: 2}};
    vecs[2] = '{s: 0, e: 8'h7F, m: 25'h0000001, x: '{s: 0, e: 8'h68, f: 23'h0,      z: 0, o: 0, u: 0, lat: 25}};
    vecs[3] = '{s: 1, e: 8'h90, m: 25'h0000000, x: '{s: 0, e: 8'h00, f: 23'h0,      z: 1, o: 0, u: 0, lat: 2}};
    vecs[4] = '{s: 0, e: 8'hFE, m: 25'h1000000, x: '{s: 0, e: 8'hFF, f: 23'h0,      z: 0, o: 1, u: 0, lat: 2}};
    vecs[5] = '{s: 0, e: 8'h02, m: 25'h0200000, x: '{s: 0, e: 8'h00, f: 23'h0,      z: 1, o: 0, u: 1, lat: 4}};
    vecs[6] = '{s: 1, e: 8'hFF, m: 25'h0800000, x: '{s: 1, e: 8'hFF, f: 23'h0,      z: 0, o: 1, u: 0, lat: 2}};
    vecs[7] = '{s: 1, e: 8'h10, m: 25'h0400001, x: '{s: 1, e: 8'h0F, f: 23'h000002, z: 0, o: 0, u: 0, lat: 3}};

    repeat (3) @(negedge clk);
    check("reset.in_ready",  32'(in_ready),  32'd0);
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.outs", 32'({out_sign, out_exp, out_zero, out_ovf, out_unf}), 32'd0);
    check("reset.frac", 32'(out_frac), 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].x, 0);

    for (int n = 0; n < 60; n++) begin
      bit        s;
      bit [7:0]  e;
      bit [24:0] m;
      s = 1'($urandom);
      e = (n % 3 == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom);
      m = 25'($urandom) >> $urandom_range(0, 25);
      run_op($sformatf("rnd%0d", n), s, e, m, model(s, e, m), 0);
    end

    xr = model(1'b1, 8'h45, 25'h0012345);
    run_op("hold", 1'b1, 8'h45, 25'h0012345, xr, 3);

    // Abort an operation while it is shifting.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'h7F; in_mant = 25'h0000001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.out_valid", 32'(out_valid), 32'd0);
    check("rst_mid.in_ready",  32'(in_ready),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid.in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("rst_mid.idle_valid", 32'(out_valid), 32'd0);
    check("rst_mid.idle_ready", 32'(in_ready),  32'd1);

    run_op("post_rst", vecs[1].s, vecs[1].e, vecs[1].m, vecs[1].x, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
